// File: rtl/ts_pkg.sv
// Shared MPEG-TS definitions used by the sync aligner, the packet-write
// controller and the RX de-encapsulator.
package ts_pkg;

    localparam logic [7:0]  TS_SYNC_BYTE = 8'h47;
    localparam int unsigned TS_LEN_MIN   = 16;
    localparam int unsigned TS_LEN_MAX   = 2047;

    // Alignment state; encodings are fixed so they stay stable across blocks.
    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCK   = 2'd2
    } ts_state_e;

    // True when a requested packet period is within the supported range.
    function automatic logic ts_len_ok(input logic [15:0] len);
        return (len >= 16'(TS_LEN_MIN)) && (len <= 16'(TS_LEN_MAX));
    endfunction

endpackage

// File: rtl/ts_sync_aligner.sv
// MPEG-TS byte-stream sync aligner: hunts for 0x47, verifies the packet
// period over LOCK_CNT syncs, then forwards only packet-aligned bytes with
// a start-of-packet flag. Loss of lock drops output on a packet boundary.
module ts_sync_aligner
    import ts_pkg::*;
#(
    parameter int unsigned LOCK_CNT   = 3,
    parameter int unsigned UNLOCK_CNT = 3
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_Valid,
    input  logic [7:0]  i_Data,
    input  logic [15:0] i_PacketLength,
    output logic        o_Valid,
    output logic        o_Sync,
    output logic [7:0]  o_Data,
    output logic        o_Locked,
    output logic        o_SyncErr,
    output logic [15:0] o_ErrCnt
);

    ts_state_e   state_q, state_d;
    logic [10:0] pos_q, pos_d;
    logic [3:0]  hits_q, hits_d;
    logic [3:0]  miss_q, miss_d;
    logic [10:0] len_q, len_d;
    logic        valid_q, valid_d;
    logic        sync_q, sync_d;
    logic [7:0]  data_q, data_d;
    logic        serr_q, serr_d;
    logic [15:0] ecnt_q, ecnt_d;

    logic        len_change;
    logic        is_sync;
    logic        at_sync;
    logic [3:0]  hits_inc;
    logic [3:0]  miss_inc;

    assign is_sync  = (i_Data == TS_SYNC_BYTE);
    assign at_sync  = (pos_q == len_q);
    assign hits_inc = hits_q + 4'd1;
    assign miss_inc = miss_q + 4'd1;

    // A period change while aligned invalidates the latched length and
    // forces a re-hunt even on idle cycles.
    assign len_change = (state_q != HUNT) &&
                        ((i_PacketLength[10:0] != len_q) || (i_PacketLength[15:11] != '0));

    // Next-state, counter and registered-output logic for the alignment FSM.
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        hits_d  = hits_q;
        miss_d  = miss_q;
        len_d   = len_q;
        valid_d = 1'b0;
        sync_d  = 1'b0;
        data_d  = data_q;
        serr_d  = 1'b0;
        ecnt_d  = ecnt_q;

        if (len_change) begin
            state_d = HUNT;
            pos_d   = '0;
            hits_d  = '0;
            miss_d  = '0;
        end else if (i_Valid) begin
            case (state_q)
                HUNT: begin
                    if (is_sync && ts_len_ok(i_PacketLength)) begin
                        state_d = VERIFY;
                        len_d   = i_PacketLength[10:0];
                        pos_d   = 11'd1;
                        hits_d  = 4'd1;
                        miss_d  = '0;
                    end
                end
                VERIFY: begin
                    if (!at_sync) begin
                        pos_d = pos_q + 11'd1;
                    end else if (is_sync) begin
                        pos_d  = 11'd1;
                        hits_d = hits_inc;
                        if (hits_inc == 4'(LOCK_CNT)) begin
                            state_d = LOCK;
                            miss_d  = '0;
                            valid_d = 1'b1;
                            sync_d  = 1'b1;
                            data_d  = i_Data;
                        end
                    end else begin
                        // Bytes skipped since the false sync are not rescanned.
                        state_d = HUNT;
                        pos_d   = '0;
                        hits_d  = '0;
                    end
                end
                LOCK: begin
                    if (!at_sync) begin
                        pos_d   = pos_q + 11'd1;
                        valid_d = 1'b1;
                        data_d  = i_Data;
                    end else begin
                        pos_d = 11'd1;
                        if (is_sync) begin
                            miss_d  = '0;
                            valid_d = 1'b1;
                            sync_d  = 1'b1;
                            data_d  = i_Data;
                        end else begin
                            miss_d = miss_inc;
                            serr_d = 1'b1;
                            if (ecnt_q != '1) begin
                                ecnt_d = ecnt_q + 16'd1;
                            end
                            if (miss_inc == 4'(UNLOCK_CNT)) begin
                                state_d = HUNT;
                                pos_d   = '0;
                                hits_d  = '0;
                                miss_d  = '0;
                            end else begin
                                // Flywheel: keep packet framing, pass the raw byte.
                                valid_d = 1'b1;
                                sync_d  = 1'b1;
                                data_d  = i_Data;
                            end
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                    pos_d   = '0;
                    hits_d  = '0;
                    miss_d  = '0;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q <= HUNT;
            pos_q   <= '0;
            hits_q  <= '0;
            miss_q  <= '0;
            len_q   <= '0;
            valid_q <= 1'b0;
            sync_q  <= 1'b0;
            data_q  <= '0;
            serr_q  <= 1'b0;
            ecnt_q  <= '0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            hits_q  <= hits_d;
            miss_q  <= miss_d;
            len_q   <= len_d;
            valid_q <= valid_d;
            sync_q  <= sync_d;
            data_q  <= data_d;
            serr_q  <= serr_d;
            ecnt_q  <= ecnt_d;
        end
    end

    assign o_Valid   = valid_q;
    assign o_Sync    = sync_q;
    assign o_Data    = data_q;
    assign o_Locked  = (state_q == LOCK);
    assign o_SyncErr = serr_q;
    assign o_ErrCnt  = ecnt_q;

endmodule

// File: tb/tb_ts_sync_aligner.sv
// Scoreboard bench for ts_sync_aligner: stimulus pushes the bytes it expects
// to see forwarded; a monitor pops and compares every o_Valid byte.
module tb_ts_sync_aligner;

    logic        i_Clk = 1'b0;
    logic        i_Rst;
    logic        i_Valid;
    logic [7:0]  i_Data;
    logic [15:0] i_PacketLength;
    logic        o_Valid;
    logic        o_Sync;
    logic [7:0]  o_Data;
    logic        o_Locked;
    logic        o_SyncErr;
    logic [15:0] o_ErrCnt;

    ts_sync_aligner #(.LOCK_CNT(3), .UNLOCK_CNT(3)) dut (
        .i_Clk          (i_Clk),
        .i_Rst          (i_Rst),
        .i_Valid        (i_Valid),
        .i_Data         (i_Data),
        .i_PacketLength (i_PacketLength),
        .o_Valid        (o_Valid),
        .o_Sync         (o_Sync),
        .o_Data         (o_Data),
        .o_Locked       (o_Locked),
        .o_SyncErr      (o_SyncErr),
        .o_ErrCnt       (o_ErrCnt)
    );

    always #5 i_Clk = ~i_Clk;

    logic [8:0] exp_q[$];
    int checks    = 0;
    int failures  = 0;
    int out_cnt   = 0;
    int sync_cnt  = 0;
    int serr_cnt  = 0;
    int base_out;
    int base_sync;
    int base_serr;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Payload generator that never produces the sync byte.
    function automatic logic [7:0] pay(input int p, input int k);
        logic [7:0] b;
        b = 8'((p * 13 + k * 3) ^ 32'h5A);
        if (b == 8'h47) b = 8'h46;
        return b;
    endfunction

    task automatic drive(input logic [7:0] d, input bit out, input bit sy);
        @(negedge i_Clk);
        i_Valid = 1'b1;
        i_Data  = d;
        if (out) exp_q.push_back({sy, d});
    endtask

    task automatic gap();
        @(negedge i_Clk);
        i_Valid = 1'b0;
    endtask

    // Outputs observed right after this task reflect the last driven byte.
    task automatic settle();
        @(negedge i_Clk);
        i_Valid = 1'b0;
    endtask

    task automatic send_pkt(input int len, input int p, input bit out,
                            input logic [7:0] sv, input int gap_pct);
        for (int k = 0; k < len; k++) begin
            if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct)
                repeat ($urandom_range(1, 3)) gap();
            drive((k == 0) ? sv : pay(p, k), out, k == 0);
        end
    endtask

    // Monitor: one comparison per forwarded byte, sync never without valid.
    always begin
        @(posedge i_Clk);
        #1;
        if (o_Valid) begin
            out_cnt++;
            if (o_Sync) sync_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out: got sync=%0d data=%0h expected no output",
                         o_Sync, o_Data);
            end else begin
                chk("out_byte", int'({o_Sync, o_Data}), int'(exp_q.pop_front()));
            end
        end else begin
            chk("sync_without_valid", int'(o_Sync), 0);
        end
        if (o_SyncErr) serr_cnt++;
    end

    initial begin
        i_Rst          = 1'b1;
        i_Valid        = 1'b0;
        i_Data         = '0;
        i_PacketLength = 16'd188;
        repeat (3) @(negedge i_Clk);
        chk("rst_valid",   int'(o_Valid),   0);
        chk("rst_sync",    int'(o_Sync),    0);
        chk("rst_data",    int'(o_Data),    0);
        chk("rst_locked",  int'(o_Locked),  0);
        chk("rst_syncerr", int'(o_SyncErr), 0);
        chk("rst_errcnt",  int'(o_ErrCnt),  0);
        i_Rst = 1'b0;

        // 10 clean 188-byte packets: output starts at the third sync.
        base_out = out_cnt; base_sync = sync_cnt;
        for (int p = 0; p < 10; p++) send_pkt(188, p, p >= 2, 8'h47, 0);
        settle();
        chk("s1_locked",    int'(o_Locked), 1);
        chk("s1_out_bytes", out_cnt - base_out, 8 * 188);
        chk("s1_out_syncs", sync_cnt - base_sync, 8);
        chk("s1_queue",     exp_q.size(), 0);

        // Two corrupted syncs ride the flywheel; the third drops lock.
        base_serr = serr_cnt;
        send_pkt(188, 10, 1'b1, 8'h00, 0);
        send_pkt(188, 11, 1'b1, 8'h00, 0);
        settle();
        chk("s2_errcnt2",  int'(o_ErrCnt), 2);
        chk("s2_locked2",  int'(o_Locked), 1);
        chk("s2_pulses2",  serr_cnt - base_serr, 2);
        drive(8'h00, 1'b0, 1'b0);
        settle();
        chk("s2_syncerr3", int'(o_SyncErr), 1);
        chk("s2_valid3",   int'(o_Valid),   0);
        chk("s2_locked3",  int'(o_Locked),  0);
        chk("s2_errcnt3",  int'(o_ErrCnt),  3);
        chk("s2_queue",    exp_q.size(), 0);

        // False sync at stream offset 50; true packets start at offset 100.
        base_out = out_cnt;
        for (int i = 0; i < 100; i++) drive((i == 50) ? 8'h47 : pay(99, i), 1'b0, 1'b0);
        for (int p = 0; p < 6; p++) send_pkt(188, 20 + p, p >= 3, 8'h47, 0);
        settle();
        chk("s3_locked",    int'(o_Locked), 1);
        chk("s3_out_bytes", out_cnt - base_out, 3 * 188);
        chk("s3_errcnt",    int'(o_ErrCnt), 3);
        chk("s3_queue",     exp_q.size(), 0);

        // Period change mid-packet while locked.
        for (int k = 0; k < 94; k++) drive((k == 0) ? 8'h47 : pay(30, k), 1'b1, k == 0);
        @(negedge i_Clk);
        i_PacketLength = 16'd204;
        i_Valid        = 1'b1;
        i_Data         = pay(30, 94);
        settle();
        chk("s4_valid",  int'(o_Valid),  0);
        chk("s4_locked", int'(o_Locked), 0);
        chk("s4_errcnt", int'(o_ErrCnt), 3);
        chk("s4_hold",   int'(o_Data),   int'(pay(30, 93)));

        // Garbage, then 204-byte packets with idle gaps.
        base_out = out_cnt; base_sync = sync_cnt;
        for (int k = 0; k < 5; k++) drive(pay(40, k + 1), 1'b0, 1'b0);
        for (int p = 0; p < 6; p++) send_pkt(204, 41 + p, p >= 2, 8'h47, 30);
        settle();
        chk("s5_locked",    int'(o_Locked), 1);
        chk("s5_out_bytes", out_cnt - base_out, 4 * 204);
        chk("s5_out_syncs", sync_cnt - base_sync, 4);
        chk("s5_queue",     exp_q.size(), 0);

        // One-cycle reset mid-packet in lock.
        for (int k = 0; k < 100; k++) drive((k == 0) ? 8'h47 : pay(50, k), 1'b1, k == 0);
        @(negedge i_Clk);
        i_Rst   = 1'b1;
        i_Valid = 1'b1;
        i_Data  = pay(50, 100);
        @(negedge i_Clk);
        chk("s6_valid",   int'(o_Valid),   0);
        chk("s6_sync",    int'(o_Sync),    0);
        chk("s6_data",    int'(o_Data),    0);
        chk("s6_locked",  int'(o_Locked),  0);
        chk("s6_errcnt",  int'(o_ErrCnt),  0);
        chk("s6_syncerr", int'(o_SyncErr), 0);
        i_Rst   = 1'b0;
        i_Valid = 1'b0;
        for (int k = 101; k < 204; k++) drive(pay(50, k), 1'b0, 1'b0);
        send_pkt(204, 51, 1'b0, 8'h47, 0);
        send_pkt(204, 52, 1'b0, 8'h47, 0);
        settle();
        chk("s6_not_yet", int'(o_Locked), 0);
        send_pkt(204, 53, 1'b1, 8'h47, 0);
        send_pkt(204, 54, 1'b1, 8'h47, 0);
        settle();
        chk("s6_relocked", int'(o_Locked), 1);

        repeat (4) settle();
        chk("final_queue", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
